tl45_execute: RTL
=================

Name: tl45_execute

Overview:
- Execute stage directly downstream of the register-read stage.
- Consumes the register-read output buffer: opcode, DR, jump condition, operand values, target offset and PC.
- Computes ALU results, holds the architectural flags register and resolves conditional jumps.
- Drives both operand-forwarding buses, runs an iterative 32-cycle multiplier that stalls upstream, and registers results into the execute buffer for writeback.

Parameters:
MUL_CYCLES, 32, number of shift-add iterations in the BUSY state (fixed at 32 for 32-bit operands).

Ports:
i_clk  input  1  clock
i_reset  input  1  synchronous, active-high reset
i_pipe_stall  input  1  stall from downstream stage
o_pipe_stall  output  1  stall to upstream stage
i_pipe_flush  input  1  flush from downstream stage
o_pipe_flush  output  1  flush to upstream stage
i_opcode  input  5  opcode from register-read buffer
i_dr  input  4  destination register
i_jmp_cond  input  4  jump condition code
i_sr1_val  input  32  operand A
i_sr2_val  input  32  operand B (immediate already substituted upstream)
i_target_address_offset  input  32  jump offset
i_pc  input  32  instruction PC
o_of1_reg  output  4  forward bus 1 register (combinational, before buffer)
o_of1_data  output  32  forward bus 1 data
o_of2_reg  output  4  forward bus 2 register (equals o_dr)
o_of2_data  output  32  forward bus 2 data (equals o_value)
o_dr  output  4  buffered destination register
o_value  output  32  buffered result
o_flags  output  4  flags register: [0]=Z, [1]=N, [2]=C, [3]=V
o_branch_taken  output  1  combinational jump redirect
o_branch_target  output  32  i_pc + i_target_address_offset, mod 2^32

Behaviour:
- Reset: o_dr, o_value, o_flags = 0; FSM = IDLE; counter = 0.
- Opcodes:
  - 0x00 NOP; any unlisted opcode also behaves as NOP.
  - 0x01 ADD; 0x02 SUB; 0x03 MUL (low 32 bits).
  - 0x04 OR; 0x05 XOR; 0x06 AND.
  - 0x07 SHL, 0x08 SHR (logical); shift amount = i_sr2_val[4:0].
  - 0x0C JMP.
- NOP and JMP write dr = 0 and value = 0.
- Flags update at the edge the instruction is registered; NOP and JMP leave them unchanged.
  - Z, N from the 32-bit result.
  - ADD: C = carry out; V = signed overflow.
  - SUB: C = borrow (A < B unsigned); V = signed overflow.
  - Logic, shift and MUL ops: C = 0, V = 0.
- Jump condition codes: 0 always, 1 Z, 2 !Z, 3 N, 4 !N, 5 C, 6 !C, 7 V, 8 !V; codes 9-15 never taken.
- o_branch_taken = (opcode == 0x0C) && condition true against the current o_flags && !i_pipe_stall && !i_pipe_flush.
  - A flag-setting instruction immediately ahead of the jump is already reflected in o_flags.
- o_pipe_flush = i_pipe_flush | o_branch_taken.
- o_pipe_stall = i_pipe_stall | (opcode == MUL && FSM != DONE).
- Single-cycle ops: 1-cycle latency, input to buffer.
  - o_of1_reg/o_of1_data show the result combinationally the same cycle.
  - o_of1_reg = 0 for NOP, JMP, while the MUL is not DONE, and while i_pipe_stall is high.
- Writes to r0 are suppressed: if i_dr == 0, buffered dr = 0 and value = 0.
- i_pipe_stall high: buffer, flags, FSM and counter hold.
- MUL FSM:
  - IDLE: a MUL input with no stall/flush captures operands; counter = 0; go to BUSY.
  - BUSY: one shift-add step per cycle; after MUL_CYCLES steps go to DONE.
  - DONE: result drives of1; on the next non-stalled edge it is registered and the FSM returns to IDLE.
  - Upstream stall is high for 33 cycles; the result appears in o_value 34 edges after the MUL first appears.
  - While not DONE, the buffer registers a bubble (dr = 0, value = 0).
- i_pipe_flush or reset in any state:
  - FSM goes to IDLE and the counter clears.
  - Buffer dr = 0, value = 0.
  - Flags are unchanged on flush and cleared on reset.

Test Plan:
- Reset then ADD dr=3, A=0x7FFFFFFF, B=1 -> same cycle of1_reg=3, of1_data=0x80000000; next cycle o_dr=3, o_value=0x80000000, flags N=1, V=1, Z=0, C=0.
- SUB A=5, B=5, then JMP cond=1, pc=0x100, offset=0x20 on the next cycle -> Z=1; o_branch_taken=1, o_branch_target=0x120, o_pipe_flush=1 for one cycle.
- MUL dr=2, A=0x12345, B=0x1000 -> o_pipe_stall high 33 cycles with bubbles in the buffer; then o_value=0x12345000, o_dr=2.
- Assert i_pipe_flush at BUSY counter 10 -> FSM IDLE, o_dr=0, no result written; a following ADD completes with 1-cycle latency.
- ADD with dr=0, A=1, B=1 -> o_dr=0, o_value=0, of1_reg=0; flags still update.
- i_pipe_stall held 3 cycles during a JMP with cond=0 -> o_branch_taken=0 while stalled; it asserts in the cycle the stall releases; o_dr and o_value held throughout.

Source files
------------

// File: rtl/tl45_execute.sv
// tl45_execute: execute stage of the TL45 pipeline.
// Computes ALU results, owns the flags register, resolves conditional jumps,
// drives both forwarding buses and runs a 32-step shift-add multiplier.
//
// Pipeline handshake: an instruction presented on the inputs is consumed
// at a rising edge only when i_pipe_stall is low and o_pipe_stall is low.
// While o_pipe_stall is high, upstream must hold its outputs unchanged.
// i_pipe_flush discards the current instruction and overrides stall.
// o_pipe_flush tells upstream to discard its own contents.
module tl45_execute #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    output logic        o_pipe_stall,
    input  logic        i_pipe_flush,
    output logic        o_pipe_flush,
    input  logic [4:0]  i_opcode,
    input  logic [3:0]  i_dr,
    input  logic [3:0]  i_jmp_cond,
    input  logic [31:0] i_sr1_val,
    input  logic [31:0] i_sr2_val,
    input  logic [31:0] i_target_address_offset,
    input  logic [31:0] i_pc,
    output logic [3:0]  o_of1_reg,
    output logic [31:0] o_of1_data,
    output logic [3:0]  o_of2_reg,
    output logic [31:0] o_of2_data,
    output logic [3:0]  o_dr,
    output logic [31:0] o_value,
    output logic [3:0]  o_flags,
    output logic        o_branch_taken,
    output logic [31:0] o_branch_target
);
    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_MUL = 5'h03;
    localparam logic [4:0] OP_OR  = 5'h04;
    localparam logic [4:0] OP_XOR = 5'h05;
    localparam logic [4:0] OP_AND = 5'h06;
    localparam logic [4:0] OP_SHL = 5'h07;
    localparam logic [4:0] OP_SHR = 5'h08;
    localparam logic [4:0] OP_JMP = 5'h0C;
    localparam int CW = $clog2(MUL_CYCLES + 1);

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

    mul_state_t    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   mcand_q, mcand_d;
    logic [31:0]   mplier_q, mplier_d;
    logic [31:0]   acc_q, acc_d;

    logic [32:0]   add_wide;
    logic [31:0]   sub_res;
    logic [31:0]   alu_value;
    logic          alu_c, alu_v, alu_writes;
    logic [3:0]    flags_new;
    logic [3:0]    wr_dr;
    logic [31:0]   wr_value;
    logic          cond_true;

    logic [3:0]    dr_q;
    logic [31:0]   value_q;
    logic [3:0]    flags_q;

    // Multiplier state register: flush and reset both return to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= MUL_IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // Multiplier next state: capture in IDLE, one shift-add per BUSY cycle.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (i_pipe_flush) begin
            state_d = MUL_IDLE;
            count_d = '0;
        end else if (!i_pipe_stall) begin
            case (state_q)
                MUL_IDLE: begin
                    if (i_opcode == OP_MUL) begin
                        mcand_d  = i_sr1_val;
                        mplier_d = i_sr2_val;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (mplier_q[0]) acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    count_d  = count_q + CW'(1);
                    if (count_q == CW'(MUL_CYCLES - 1)) state_d = MUL_DONE;
                end
                MUL_DONE: state_d = MUL_IDLE;
                default:  state_d = MUL_IDLE;
            endcase
        end
    end

    // ALU result, flag values, write suppression and jump condition.
    always_comb begin
        add_wide   = {1'b0, i_sr1_val} + {1'b0, i_sr2_val};
        sub_res    = i_sr1_val - i_sr2_val;
        alu_value  = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_writes = 1'b0;
        case (i_opcode)
            OP_ADD: begin
                alu_value  = add_wide[31:0];
                alu_c      = add_wide[32];
                alu_v      = (i_sr1_val[31] == i_sr2_val[31]) && (add_wide[31] != i_sr1_val[31]);
                alu_writes = 1'b1;
            end
            OP_SUB: begin
                alu_value  = sub_res;
                alu_c      = i_sr1_val < i_sr2_val;
                alu_v      = (i_sr1_val[31] != i_sr2_val[31]) && (sub_res[31] != i_sr1_val[31]);
                alu_writes = 1'b1;
            end
            OP_MUL: begin
                if (state_q == MUL_DONE) begin
                    alu_value  = acc_q;
                    alu_writes = 1'b1;
                end
            end
            OP_OR:  begin alu_value = i_sr1_val | i_sr2_val;        alu_writes = 1'b1; end
            OP_XOR: begin alu_value = i_sr1_val ^ i_sr2_val;        alu_writes = 1'b1; end
            OP_AND: begin alu_value = i_sr1_val & i_sr2_val;        alu_writes = 1'b1; end
            OP_SHL: begin alu_value = i_sr1_val << i_sr2_val[4:0];  alu_writes = 1'b1; end
            OP_SHR: begin alu_value = i_sr1_val >> i_sr2_val[4:0];  alu_writes = 1'b1; end
            default: ;
        endcase
        flags_new = {alu_v, alu_c, alu_value[31], alu_value == 32'd0};
        // r0 is hardwired to zero, so its writes become bubbles.
        wr_dr    = (alu_writes && i_dr != 4'd0) ? i_dr : 4'd0;
        wr_value = (alu_writes && i_dr != 4'd0) ? alu_value : 32'd0;
        case (i_jmp_cond)
            4'd0:    cond_true = 1'b1;
            4'd1:    cond_true = flags_q[0];
            4'd2:    cond_true = !flags_q[0];
            4'd3:    cond_true = flags_q[1];
            4'd4:    cond_true = !flags_q[1];
            4'd5:    cond_true = flags_q[2];
            4'd6:    cond_true = !flags_q[2];
            4'd7:    cond_true = flags_q[3];
            4'd8:    cond_true = !flags_q[3];
            default: cond_true = 1'b0;
        endcase
    end

    // Execute buffer and flags register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            dr_q    <= '0;
            value_q <= '0;
            flags_q <= '0;
        end else if (i_pipe_flush) begin
            dr_q    <= '0;
            value_q <= '0;
        end else if (!i_pipe_stall) begin
            dr_q    <= wr_dr;
            value_q <= wr_value;
            if (alu_writes) flags_q <= flags_new;
        end
    end

    assign o_branch_taken  = (i_opcode == OP_JMP) && cond_true && !i_pipe_stall && !i_pipe_flush;
    assign o_branch_target = i_pc + i_target_address_offset;
    assign o_pipe_flush    = i_pipe_flush | o_branch_taken;
    assign o_pipe_stall    = i_pipe_stall | ((i_opcode == OP_MUL) && (state_q != MUL_DONE));
    assign o_of1_reg       = i_pipe_stall ? 4'd0 : wr_dr;
    assign o_of1_data      = i_pipe_stall ? 32'd0 : wr_value;
    assign o_dr            = dr_q;
    assign o_value         = value_q;
    assign o_of2_reg       = dr_q;
    assign o_of2_data      = value_q;
    assign o_flags         = flags_q;

endmodule
